// File: rtl/de2_70_ethernet_st_error_expander.sv
// ---------------------------------------------------------------------------
// de2_70_ethernet_st_error_expander
//
// Avalon-ST error expander sitting in front of the MAC TX port. It takes a
// stream that carries a single error bit per beat and re-widens it to the
// MAC's multi-bit error field. Along the way it checks SOP/EOP framing:
//   * beats that arrive outside a packet (no SOP while idle) are accepted
//     and dropped ("orphans");
//   * an SOP inside an open packet ("nested SOP") is forwarded as a normal
//     mid-packet beat with its SOP stripped and a framing error bit raised.
// Errors are accumulated over a packet so that the EOP beat carries the OR
// of every error seen in that packet.
//
// The datapath is fully registered: an output register plus a one-beat skid
// register. in_ready is itself a flop (it is the registered "skid empty"
// flag), so no combinational path runs from out_ready to in_ready.
//
// Build option:
//   STERR_STATS_EN  when defined, adds the CNT_W parameter and the
//                   err_pkt_cnt / orphan_cnt saturating statistics ports.
//                   The datapath is identical either way.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   in_*                   Avalon-ST sink (1-bit error)
//   out_*                  Avalon-ST source (ERR_OUT_W-bit error)
//   err_pkt_cnt            forwarded EOP beats carrying any error (stats only)
//   orphan_cnt             orphan beats dropped (stats only)
// ---------------------------------------------------------------------------
module de2_70_ethernet_st_error_expander #(
    parameter int DATA_W      = 32,
    parameter int EMPTY_W     = 2,
    parameter int ERR_OUT_W   = 6,
    parameter int IN_ERR_POS  = 0,
    parameter int SOP_ERR_POS = 4
`ifdef STERR_STATS_EN
    ,
    parameter int CNT_W       = 16
`endif
) (
    input  logic                 clk,
    input  logic                 reset_n,

    output logic                 in_ready,
    input  logic                 in_valid,
    input  logic [DATA_W-1:0]    in_data,
    input  logic                 in_error,
    input  logic                 in_startofpacket,
    input  logic                 in_endofpacket,
    input  logic [EMPTY_W-1:0]   in_empty,

    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [DATA_W-1:0]    out_data,
    output logic [ERR_OUT_W-1:0] out_error,
    output logic                 out_startofpacket,
    output logic                 out_endofpacket,
    output logic [EMPTY_W-1:0]   out_empty
`ifdef STERR_STATS_EN
    ,
    output logic [CNT_W-1:0]     err_pkt_cnt,
    output logic [CNT_W-1:0]     orphan_cnt
`endif
);

    // -----------------------------------------------------------------------
    // Types
    // -----------------------------------------------------------------------
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0]    data;
        logic [ERR_OUT_W-1:0] err;
        logic                 sop;
        logic                 eop;
        logic [EMPTY_W-1:0]   empty;
    } beat_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t state_q,      state_d;
    logic   sticky_q,     sticky_d;      // any error so far in the open packet
    logic   sticky_sop_q, sticky_sop_d;  // nested SOP seen in the open packet

    logic   in_ready_q,   in_ready_d;

    logic   out_valid_q,  out_valid_d;
    beat_t  out_beat_q,   out_beat_d;

    logic   skid_valid_q, skid_valid_d;
    beat_t  skid_beat_q,  skid_beat_d;

`ifdef STERR_STATS_EN
    logic [CNT_W-1:0] err_pkt_cnt_q, err_pkt_cnt_d;
    logic [CNT_W-1:0] orphan_cnt_q,  orphan_cnt_d;
`endif

    // -----------------------------------------------------------------------
    // Input classification and error mapping
    // -----------------------------------------------------------------------
    logic  accept;
    logic  in_pkt;
    logic  orphan;
    logic  nested;
    logic  beat_valid;
    beat_t beat;

    always_comb begin
        accept     = in_valid & in_ready_q;
        in_pkt     = (state_q == ST_PKT);
        orphan     = accept & ~in_pkt & ~in_startofpacket;
        nested     = accept &  in_pkt &  in_startofpacket;
        beat_valid = accept & ~orphan;

        beat       = '0;
        beat.data  = in_data;
        beat.empty = in_empty;
        // A nested SOP is forwarded as an ordinary mid-packet beat.
        beat.sop   = in_startofpacket & ~in_pkt;
        beat.eop   = in_endofpacket;

        // The EOP beat reports the whole packet, including this beat's own
        // framing error. Both sticky flags are 0 in IDLE, so a single-beat
        // packet only ever reports its own error.
        beat.err[IN_ERR_POS]  = in_error
                              | (in_endofpacket & (sticky_q | nested));
        // OR-ing in keeps both flags visible if the two positions coincide.
        beat.err[SOP_ERR_POS] = beat.err[SOP_ERR_POS]
                              | nested
                              | (in_endofpacket & sticky_sop_q);
    end

    // -----------------------------------------------------------------------
    // Framing FSM: advances on accepted beats only
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        sticky_d     = sticky_q;
        sticky_sop_d = sticky_sop_q;

        if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    // SOP+EOP is a complete single-beat packet: stay idle
                    // and leave nothing sticky behind. No SOP is an orphan.
                    if (in_startofpacket && !in_endofpacket) begin
                        state_d      = ST_PKT;
                        sticky_d     = in_error;
                        sticky_sop_d = 1'b0;
                    end
                end
                ST_PKT: begin
                    if (in_endofpacket) begin
                        state_d      = ST_IDLE;
                        sticky_d     = 1'b0;
                        sticky_sop_d = 1'b0;
                    end else begin
                        sticky_d     = sticky_q | in_error | nested;
                        sticky_sop_d = sticky_sop_q | nested;
                    end
                end
                default: begin
                    state_d      = ST_IDLE;
                    sticky_d     = 1'b0;
                    sticky_sop_d = 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output register + skid register
    //
    // in_ready_q is only ever 1 while the skid is empty, so a new beat always
    // has a place to go: straight to the output if it frees up this cycle,
    // otherwise into the skid. When the output frees up and the skid is
    // occupied, the skid drains first to keep beats in order.
    // -----------------------------------------------------------------------
    logic out_free;

    always_comb begin
        out_free     = ~out_valid_q | out_ready;

        out_valid_d  = out_valid_q;
        out_beat_d   = out_beat_q;
        skid_valid_d = skid_valid_q;
        skid_beat_d  = skid_beat_q;

        if (out_free) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_beat_d   = skid_beat_q;
                skid_valid_d = beat_valid;
                if (beat_valid) begin
                    skid_beat_d = beat;
                end
            end else begin
                out_valid_d = beat_valid;
                if (beat_valid) begin
                    out_beat_d = beat;
                end
            end
        end else if (beat_valid) begin
            skid_valid_d = 1'b1;
            skid_beat_d  = beat;
        end

        in_ready_d = ~skid_valid_d;
    end

    // -----------------------------------------------------------------------
    // Statistics
    // -----------------------------------------------------------------------
`ifdef STERR_STATS_EN
    always_comb begin
        err_pkt_cnt_d = err_pkt_cnt_q;
        orphan_cnt_d  = orphan_cnt_q;

        // Counted when the errored EOP beat actually leaves the block.
        if (out_valid_q && out_ready && out_beat_q.eop && (|out_beat_q.err)
            && (err_pkt_cnt_q != {CNT_W{1'b1}})) begin
            err_pkt_cnt_d = err_pkt_cnt_q + CNT_W'(1);
        end

        if (orphan && (orphan_cnt_q != {CNT_W{1'b1}})) begin
            orphan_cnt_d = orphan_cnt_q + CNT_W'(1);
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            sticky_q      <= 1'b0;
            sticky_sop_q  <= 1'b0;
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            out_beat_q    <= '0;
            skid_valid_q  <= 1'b0;
            skid_beat_q   <= '0;
`ifdef STERR_STATS_EN
            err_pkt_cnt_q <= '0;
            orphan_cnt_q  <= '0;
`endif
        end else begin
            state_q       <= state_d;
            sticky_q      <= sticky_d;
            sticky_sop_q  <= sticky_sop_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            out_beat_q    <= out_beat_d;
            skid_valid_q  <= skid_valid_d;
            skid_beat_q   <= skid_beat_d;
`ifdef STERR_STATS_EN
            err_pkt_cnt_q <= err_pkt_cnt_d;
            orphan_cnt_q  <= orphan_cnt_d;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign in_ready          = in_ready_q;
    assign out_valid         = out_valid_q;
    assign out_data          = out_beat_q.data;
    assign out_error         = out_beat_q.err;
    assign out_startofpacket = out_beat_q.sop;
    assign out_endofpacket   = out_beat_q.eop;
    assign out_empty         = out_beat_q.empty;

`ifdef STERR_STATS_EN
    assign err_pkt_cnt       = err_pkt_cnt_q;
    assign orphan_cnt        = orphan_cnt_q;
`endif

endmodule

// File: tb/tb_de2_70_ethernet_st_error_expander.sv
// ---------------------------------------------------------------------------
// Testbench for de2_70_ethernet_st_error_expander.
// Directed stimulus in one initial block; every forwarded beat's expected
// value is pushed to a scoreboard queue when it is driven, and a negedge
// monitor pops and compares each beat the DUT transfers.
// ---------------------------------------------------------------------------
module tb_de2_70_ethernet_st_error_expander;

    localparam int DATA_W    = 32;
    localparam int EMPTY_W   = 2;
    localparam int ERR_OUT_W = 6;
    localparam int CNT_W     = 16;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 in_ready;
    logic                 in_valid;
    logic [DATA_W-1:0]    in_data;
    logic                 in_error;
    logic                 in_startofpacket;
    logic                 in_endofpacket;
    logic [EMPTY_W-1:0]   in_empty;
    logic                 out_ready;
    logic                 out_valid;
    logic [DATA_W-1:0]    out_data;
    logic [ERR_OUT_W-1:0] out_error;
    logic                 out_startofpacket;
    logic                 out_endofpacket;
    logic [EMPTY_W-1:0]   out_empty;
`ifdef STERR_STATS_EN
    logic [CNT_W-1:0]     err_pkt_cnt;
    logic [CNT_W-1:0]     orphan_cnt;
`endif

    always #5 clk = ~clk;

    de2_70_ethernet_st_error_expander dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .in_ready          (in_ready),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .in_error          (in_error),
        .in_startofpacket  (in_startofpacket),
        .in_endofpacket    (in_endofpacket),
        .in_empty          (in_empty),
        .out_ready         (out_ready),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .out_error         (out_error),
        .out_startofpacket (out_startofpacket),
        .out_endofpacket   (out_endofpacket),
        .out_empty         (out_empty)
`ifdef STERR_STATS_EN
        ,
        .err_pkt_cnt       (err_pkt_cnt),
        .orphan_cnt        (orphan_cnt)
`endif
    );

    // {data, error, sop, eop, empty}
    typedef logic [DATA_W+ERR_OUT_W+2+EMPTY_W-1:0] beat_t;

    beat_t sb[$];
    int    checks = 0;
    int    errors = 0;
    logic  stalled = 1'b0;
    beat_t held;
    logic  saw_not_ready = 1'b0;
    logic  stream_done;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: compares every transfer against the scoreboard and
    // checks the source holds its beat steady while stalled.
    always @(negedge clk) begin
        beat_t cur;
        beat_t e;
        cur = {out_data, out_error, out_startofpacket, out_endofpacket, out_empty};
        if (in_valid === 1'b1 && in_ready === 1'b0)
            saw_not_ready = 1'b1;
        if (reset_n === 1'b1 && out_valid === 1'b1) begin
            if (stalled)
                check("stable_while_stalled", 64'(cur), 64'(held));
            if (out_ready === 1'b1) begin
                check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("out_beat", 64'(cur), 64'(e));
                    $display("beat out: data=0x%0h err=0x%0h sop=%0b eop=%0b empty=%0d",
                             out_data, out_error, out_startofpacket, out_endofpacket, out_empty);
                end
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held    = cur;
            end
        end else begin
            stalled = 1'b0;
        end
    end

    // Drive one beat, push its expectation (if forwarded), wait for accept.
    task automatic send(input logic [DATA_W-1:0] d, input logic err, input logic sop,
                        input logic eop, input logic [EMPTY_W-1:0] emp, input logic fwd,
                        input logic [ERR_OUT_W-1:0] exp_err, input logic exp_sop);
        bit done = 0;
        int n    = 0;
        in_valid         = 1'b1;
        in_data          = d;
        in_error         = err;
        in_startofpacket = sop;
        in_endofpacket   = eop;
        in_empty         = emp;
        if (fwd)
            sb.push_back({d, exp_err, exp_sop, eop, emp});
        while (!done) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                done = 1;
            end else begin
                n++;
                if (n > 200) begin
                    check("accept_timeout", 64'(in_ready), 64'd1);
                    done = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        reset_n          = 1'b0;
        in_valid         = 1'b0;
        in_data          = '0;
        in_error         = 1'b0;
        in_startofpacket = 1'b0;
        in_endofpacket   = 1'b0;
        in_empty         = '0;
        out_ready        = 1'b1;
        stream_done      = 1'b0;

        // 1. Reset state and in_ready rising one edge after release
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_error", 64'(out_error), 64'd0);
        reset_n = 1'b1;
        #1;
        check("in_ready_before_edge", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        check("in_ready_after_edge", 64'(in_ready), 64'd1);
        check("out_valid_after_rst", 64'(out_valid), 64'd0);

        // 2. Clean 4-beat packet
        send(32'h11, 0, 1, 0, 2'd0, 1, 6'h00, 1);
        send(32'h22, 0, 0, 0, 2'd0, 1, 6'h00, 0);
        send(32'h33, 0, 0, 0, 2'd0, 1, 6'h00, 0);
        send(32'h44, 0, 0, 1, 2'd2, 1, 6'h00, 0);
        drain();

        // 3. Error on beat 2 propagates to EOP
        send(32'h101, 0, 1, 0, 2'd0, 1, 6'h00, 1);
        send(32'h102, 1, 0, 0, 2'd0, 1, 6'h01, 0);
        send(32'h103, 0, 0, 1, 2'd1, 1, 6'h01, 0);
        drain();
`ifdef STERR_STATS_EN
        check("err_pkt_cnt_t3", 64'(err_pkt_cnt), 64'd1);
`endif

        // 4. Orphan beat dropped, following packet unaffected
        send(32'hDEAD, 0, 0, 0, 2'd0, 0, 6'h00, 0);
        drain();
`ifdef STERR_STATS_EN
        check("orphan_cnt_t4", 64'(orphan_cnt), 64'd1);
`endif
        send(32'hA1, 0, 1, 0, 2'd0, 1, 6'h00, 1);
        send(32'hA2, 0, 0, 1, 2'd3, 1, 6'h00, 0);
        drain();

        // Single-beat SOP+EOP with error, then a clean packet: nothing sticky
        send(32'h55, 1, 1, 1, 2'd0, 1, 6'h01, 1);
        send(32'h66, 0, 1, 0, 2'd0, 1, 6'h00, 1);
        send(32'h67, 0, 0, 1, 2'd0, 1, 6'h00, 0);
        drain();
`ifdef STERR_STATS_EN
        check("err_pkt_cnt_single", 64'(err_pkt_cnt), 64'd2);
`endif

        // 5. Nested SOP
        send(32'h71, 0, 1, 0, 2'd0, 1, 6'h00, 1);
        send(32'h72, 0, 1, 0, 2'd0, 1, 6'h10, 0);
        send(32'h73, 0, 0, 1, 2'd0, 1, 6'h11, 0);
        drain();

        // Backpressure: output reg + skid fill, then in_ready drops
        out_ready = 1'b0;
        send(32'h81, 0, 1, 0, 2'd0, 1, 6'h00, 1);
        send(32'h82, 0, 0, 0, 2'd0, 1, 6'h00, 0);
        @(negedge clk);
        check("skid_full_in_ready", 64'(in_ready), 64'd0);
        check("stalled_out_valid", 64'(out_valid), 64'd1);
        check("stalled_out_data", 64'(out_data), 64'h81);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(32'h83, 0, 0, 1, 2'd0, 1, 6'h00, 0);
        drain();

        // 6. out_ready toggling 1010 during a 6-beat stream
        saw_not_ready = 1'b0;
        fork
            begin
                send(32'h91, 0, 1, 0, 2'd0, 1, 6'h00, 1);
                send(32'h92, 0, 0, 0, 2'd0, 1, 6'h00, 0);
                send(32'h93, 1, 0, 0, 2'd0, 1, 6'h01, 0);
                send(32'h94, 0, 0, 0, 2'd0, 1, 6'h00, 0);
                send(32'h95, 0, 0, 0, 2'd0, 1, 6'h00, 0);
                send(32'h96, 0, 0, 1, 2'd0, 1, 6'h01, 0);
                stream_done = 1'b1;
            end
            begin
                int n = 0;
                while (!stream_done && n < 500) begin
                    out_ready = 1'b1;
                    @(posedge clk);
                    #1;
                    out_ready = 1'b0;
                    @(posedge clk);
                    #1;
                    n++;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("in_ready_dropped_t6", 64'(saw_not_ready), 64'd1);

        // Reset in mid-packet discards the buffered beat; FSM back to IDLE
        out_ready = 1'b0;
        send(32'hB1, 0, 1, 0, 2'd0, 1, 6'h00, 1);
        @(negedge clk);
        reset_n = 1'b0;
        sb.delete();
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(32'hB2, 0, 0, 1, 2'd0, 0, 6'h00, 0);
        drain();
`ifdef STERR_STATS_EN
        check("orphan_cnt_after_rst", 64'(orphan_cnt), 64'd1);
        check("err_pkt_cnt_after_rst", 64'(err_pkt_cnt), 64'd0);
`endif
        send(32'hC1, 0, 1, 1, 2'd1, 1, 6'h00, 1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
